// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: processes CHUNK bits per cycle
// through a ripple carry, then applies optional signed saturation and registers {N,Z,V}.
module addsub_seq #(
  parameter int WIDTH       = 16,
  parameter int CHUNK       = 4,
  parameter int SAT_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic [2:0]       flag
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0 || SAT_DEFAULT > 1) begin : g_bad_params
      $error("addsub_seq: illegal WIDTH/CHUNK/SAT_DEFAULT combination");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t                    r_state;
  logic signed [WIDTH-1:0]   r_a;
  logic signed [WIDTH-1:0]   r_b;
  logic        [WIDTH-1:0]   r_sum;
  logic                      r_carry;
  logic                      r_sat;
  logic        [CNT_W-1:0]   r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic        [WIDTH-1:0]   r_s;
  logic        [2:0]         r_flag;

  logic        [CHUNK-1:0]   w_a_chk;
  logic        [CHUNK-1:0]   w_b_chk;
  logic        [CHUNK:0]     w_csum;
  logic        [WIDTH-1:0]   w_raw;
  logic                      w_v;
  logic signed [WIDTH-1:0]   w_res;
  logic                      w_last;

  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ovf,
    input logic                    en,
    input logic                    a_neg
  );
    if (en && ovf)
      return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return raw;
  endfunction

  // Stage: one chunk of the ripple add; the final chunk is spliced in so the
  // full raw sum is visible on the same edge that registers the result.
  always_comb begin
    w_a_chk = r_a[r_cnt*CHUNK +: CHUNK];
    w_b_chk = r_b[r_cnt*CHUNK +: CHUNK];
    w_csum  = {1'b0, w_a_chk} + {1'b0, w_b_chk} + (CHUNK+1)'(r_carry);
    w_raw   = r_sum;
    w_raw[r_cnt*CHUNK +: CHUNK] = w_csum[CHUNK-1:0];
    w_v     = (r_a[MSB] == r_b[MSB]) && (w_raw[MSB] != r_a[MSB]);
    w_res   = saturate(signed'(w_raw), w_v, r_sat, r_a[MSB]);
    w_last  = (r_cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_flag  <= 3'b000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_CALC: begin
          r_sum[r_cnt*CHUNK +: CHUNK] <= w_csum[CHUNK-1:0];
          r_carry <= w_csum[CHUNK];
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_s     <= w_res;
            r_flag  <= {w_res[MSB], (w_res == '0), w_v};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            r_state <= ST_CALC;
            r_a     <= signed'(A);
            r_b     <= signed'(sub ? ~B : B);
            r_carry <= sub;
            r_sat   <= sat_en;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign flag = r_flag;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed table, random ops against an
// arithmetic reference model, and hand sequences for restart/reset corners.
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, sat_en;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] S;
  logic [2:0]  flag;

  logic        start8, sub8, sat8;
  logic [7:0]  A8, B8;
  logic        busy8, done8;
  logic [7:0]  S8;
  logic [2:0]  flag8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(16), .CHUNK(4), .SAT_DEFAULT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sub(sub), .sat_en(sat_en),
    .busy(busy), .done(done), .S(S), .flag(flag)
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8), .SAT_DEFAULT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .sub(sub8), .sat_en(sat8),
    .busy(busy8), .done(done8), .S(S8), .flag(flag8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sb;
    logic        st;
    logic [15:0] s;
    logic [2:0]  f;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, overflow = result outside signed 16-bit range.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sb, input logic st);
    longint x, y, r;
    logic [15:0] s;
    logic v;
    x = longint'($signed(a));
    y = longint'($signed(b));
    r = sb ? x - y : x + y;
    v = (r > 32767) || (r < -32768);
    if (v && st) s = (r > 0) ? 16'h7FFF : 16'h8000;
    else         s = r[15:0];
    return {s, s[15], (s == 16'h0000), v};
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sb,
                        input logic st, output logic [15:0] s, output logic [2:0] f,
                        output int lat);
    logic [15:0] prev_s;
    @(negedge clk);
    check("done_is_pulse", done, 1'b0);
    A = a; B = b; sub = sb; sat_en = st; start = 1'b1;
    prev_s = S;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      check("busy_in_calc", busy, 1'b1);
      check("s_held_in_calc", S, prev_s);
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check("done_timeout", 0, 1);
    check("busy_low_at_done", busy, 1'b0);
    s = S;
    f = flag;
  endtask

  initial begin
    logic [15:0] s, ra, rb;
    logic [2:0]  f;
    logic [18:0] m;
    logic        rsb, rst_;
    int          lat, npulse;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; sub = 1'b0; sat_en = 1'b0;
    start8 = 1'b0; A8 = '0; B8 = '0; sub8 = 1'b0; sat8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_S", S, 16'h0000);
    check("rst_flag", flag, 3'b000);
    rst = 1'b0;

    tbl[0] = '{16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 3'b000};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 3'b001};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 3'b101};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 3'b101};
    tbl[4] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 3'b010};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 3'b010};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 3'b001};
    tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 3'b101};
    tbl[8] = '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 3'b001};
    tbl[9] = '{16'h1234, 16'h0235, 1'b1, 1'b0, 16'h0FFF, 3'b000};

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sb, tbl[i].st, s, f, lat);
      check($sformatf("tbl%0d_S", i), s, tbl[i].s);
      check($sformatf("tbl%0d_flag", i), f, tbl[i].f);
      check($sformatf("tbl%0d_lat", i), lat, 4);
    end

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb   = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      rsb  = 1'($urandom);
      rst_ = 1'($urandom);
      m = model(ra, rb, rsb, rst_);
      run_op(ra, rb, rsb, rst_, s, f, lat);
      check($sformatf("rnd%0d_S", i), s, m[18:3]);
      check($sformatf("rnd%0d_flag", i), f, m[2:0]);
    end

    // start pulsed mid-operation with different operands must be ignored
    @(negedge clk);
    A = 16'h0003; B = 16'h0004; sub = 1'b0; sat_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'h1000; B = 16'h2000; sub = 1'b1; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("midstart_lat", lat, 4);
    check("midstart_S", S, 16'h0007);
    check("midstart_flag", flag, 3'b000);
    @(negedge clk);
    check("midstart_idle", busy, 1'b0);

    // start held high: a result every 5 cycles
    A = 16'h0100; B = 16'h00FF; sub = 1'b0; sat_en = 1'b0; start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check($sformatf("b2b_done_c%0d", c), done, (c % 5 == 4) ? 1'b1 : 1'b0);
      if (c % 5 == 4) check($sformatf("b2b_S_c%0d", c), S, 16'h01FF);
    end
    start = 1'b0;

    // reset during the second CALC cycle aborts without a done
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_S", S, 16'h0000);
    check("abort_flag", flag, 3'b000);
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("abort_no_done", npulse, 0);

    // start coincident with reset is ignored
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, s, f, lat);
    check("pre_rst_S", s, 16'h0030);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rststart_busy", busy, 1'b0);
    check("rststart_S", S, 16'h0000);
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy || done) npulse++;
    end
    check("rststart_no_op", npulse, 0);

    // single-chunk configuration
    @(negedge clk);
    A8 = 8'h7F; B8 = 8'h01; sub8 = 1'b0; sat8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("w8_busy", busy8, 1'b1);
    lat = 0;
    while (done8 !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w8_lat", lat, 1);
    check("w8_S", S8, 8'h7F);
    check("w8_flag", flag8, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; SHALL divide WIDTH exactly; N = WIDTH/CHUNK.
REQ-003 Parameter SAT_DEFAULT, default 1: value sat_en takes when tied off by integrator; no effect on logic.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  request; sampled only when not busy.
REQ-008 A  input  WIDTH  two's-complement operand A.
REQ-009 B  input  WIDTH  two's-complement operand B.
REQ-010 sub  input  1  0 = A+B, 1 = A-B.
REQ-011 sat_en  input  1  1 = saturate on signed overflow, 0 = wrap.
REQ-012 busy  output  1  high while operation in progress.
REQ-013 done  output  1  one-cycle pulse, result valid.
REQ-014 S  output  WIDTH  registered result.
REQ-015 flag  output  3  registered {N, Z, V}, flag[2]=N, flag[1]=Z, flag[0]=V.

Function
REQ-016 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-017 IDLE: start=1 at an edge -> latch A, Beff = sub ? ~B : B, carry = sub, sat_en; chunk counter = 0; next state CALC.
REQ-018 CALC: each edge adds chunk k of A and Beff plus carry, stores CHUNK sum bits, updates carry, increments counter; chunk 0 = LSBs.
REQ-019 CALC -> DONE at the edge processing chunk N-1; that same edge registers S and flag.
REQ-020 DONE lasts exactly one cycle; start=1 in DONE is accepted as in IDLE (-> CALC), else -> IDLE.
REQ-021 start in CALC SHALL be ignored; latched operands SHALL not change.
REQ-022 Latency: start sampled at edge t -> done high in cycle following edge t+N; back-to-back throughput one result per N+1 cycles.
REQ-023 busy = 1 in CALC, 0 in IDLE and DONE; done = 1 only in DONE.
REQ-024 Overflow V = (A[MSB] == Beff[MSB]) & (raw[MSB] != A[MSB]), raw = full WIDTH-bit wrapped sum.
REQ-025 sat_en=1 and V=1: S = A[MSB] ? 1 followed by WIDTH-1 zeros (most negative) : 0 followed by WIDTH-1 ones (most positive).
REQ-026 Otherwise S = raw.
REQ-027 N = S[MSB]; Z = (S == 0); V per REQ-024, reported even when saturated or sat_en=0.
REQ-028 S and flag SHALL hold value from last DONE until next DONE; unchanged during CALC.
REQ-029 CHUNK = WIDTH (N=1): CALC lasts one edge; latency 1 result per 2 cycles.
REQ-030 Carry out of MSB SHALL not be an output and SHALL not affect V.

Reset
REQ-031 rst=1 at an edge: state IDLE, busy=0, done=0, S=0, flag=3'b000, counter=0, internal registers cleared.
REQ-032 rst has priority over start and over any in-progress operation; an aborted operation SHALL never produce done.
REQ-033 start sampled together with rst SHALL be ignored.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-034 A=0x0003, B=0x0004, sub=0, start at edge t -> done in cycle after t+4, S=0x0007, flag=000; busy high 4 cycles.
REQ-035 A=0x7FFF, B=0x0001, sub=0: sat_en=1 -> S=0x7FFF, flag=001; sat_en=0 -> S=0x8000, flag=101.
REQ-036 A=0x8000, B=0x0001, sub=1, sat_en=1 -> S=0x8000, flag=101; A=0x0005, B=0x0005, sub=1 -> S=0x0000, flag=010.
REQ-037 start pulsed mid-CALC with new operands -> ignored, result of first op; start held high through DONE -> second op begins, done every 5 cycles.
REQ-038 rst asserted in 2nd CALC cycle -> next cycle busy=0, done=0, S=0, flag=000; no done pulse follows.
REQ-039 WIDTH=8, CHUNK=8: A=0x7F, B=0x01, sat_en=1 -> done 1 cycle after start, S=0x7F, flag=001.
